// File: rtl/nic_tx_fifo_if.sv
// OS-side write port and controller-side transmit handshake for the NIC TX byte FIFO.
// master: the OS writer plus UART controller; slave: the FIFO itself.
interface nic_tx_fifo_if #(
    parameter int ADDR_W = 3
);
    logic              wr_en;
    logic [7:0]        wr_data;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              clr_ovf;

    modport master (
        output wr_en, wr_data, tx_ready, clr_ovf,
        input  tx_data, tx_valid, full, empty, almost_full, count, overflow
    );

    modport slave (
        input  wr_en, wr_data, tx_ready, clr_ovf,
        output tx_data, tx_valid, full, empty, almost_full, count, overflow
    );
endinterface

// File: rtl/nic_tx_fifo.sv
// Byte FIFO from the OS send path to the UART transmitter, first-word-fall-through.
// Latency: a write into an empty queue is visible on tx_data/tx_valid one cycle later.
// Backpressure: tx_ready stalls the head; writes when full are dropped and flagged sticky.
module nic_tx_fifo #(
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 3,
    parameter int AF_THRESH = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    nic_tx_fifo_if.slave  bus
);
    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   AF_CNT   = (ADDR_W + 1)'(AF_THRESH);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   cnt;
    logic              ovf;

    logic is_empty;
    logic is_full;
    logic pop;
    logic push;
    logic drop;

    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == FULL_CNT);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
    assign pop  = !is_empty && bus.tx_ready;
    assign push = bus.wr_en && (!is_full || pop);
    assign drop = bus.wr_en && is_full && !pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                ovf <= 1'b1;
            end else if (bus.clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    assign bus.tx_data     = mem[rd_ptr];
    assign bus.tx_valid    = !is_empty;
    assign bus.full        = is_full;
    assign bus.empty       = is_empty;
    assign bus.almost_full = (cnt >= AF_CNT);
    assign bus.count       = cnt;
    assign bus.overflow    = ovf;
endmodule

// File: tb/tb_nic_tx_fifo.sv
// Directed vector table plus hand sequences for streaming wrap and mid-burst reset.
module tb_nic_tx_fifo;
    localparam int DEPTH     = 8;
    localparam int ADDR_W    = 3;
    localparam int AF_THRESH = 6;

    logic clk;
    logic rst_n;

    nic_tx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

    nic_tx_fifo #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .AF_THRESH(AF_THRESH)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst_n;
        logic       wr_en;
        logic [7:0] wr_data;
        logic       tx_ready;
        logic       clr_ovf;
        int         exp_cnt;
        logic [7:0] exp_data;
        logic       exp_ovf;
    } vec_t;

    vec_t tbl[$];
    int   total;
    int   bad;

    task automatic add(input logic r, input logic w, input logic [7:0] d, input logic rdy,
                       input logic clr, input int ecnt, input logic [7:0] edat, input logic eovf);
        vec_t v;
        v.rst_n    = r;
        v.wr_en    = w;
        v.wr_data  = d;
        v.tx_ready = rdy;
        v.clr_ovf  = clr;
        v.exp_cnt  = ecnt;
        v.exp_data = edat;
        v.exp_ovf  = eovf;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s step=%0d got=0x%0h want=0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [7:0] d,
                         input logic rdy, input logic clr);
        rst_n        = r;
        bus.wr_en    = w;
        bus.wr_data  = d;
        bus.tx_ready = rdy;
        bus.clr_ovf  = clr;
    endtask

    // Flags are defined purely by occupancy, so they are checked against the expected count.
    task automatic chk_state(input int idx, input int ecnt, input logic [7:0] edat, input logic eovf);
        chk("count", idx, int'(bus.count), ecnt);
        chk("tx_valid", idx, int'(bus.tx_valid), int'(ecnt != 0));
        chk("empty", idx, int'(bus.empty), int'(ecnt == 0));
        chk("full", idx, int'(bus.full), int'(ecnt == DEPTH));
        chk("almost_full", idx, int'(bus.almost_full), int'(ecnt >= AF_THRESH));
        chk("overflow", idx, int'(bus.overflow), int'(eovf));
        if (ecnt != 0) chk("tx_data", idx, int'(bus.tx_data), int'(edat));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sb[$];
        logic [7:0] b;
        int  mc;
        int  i;
        logic rdy;
        logic mpop;
        logic mpush;

        total = 0;
        bad   = 0;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Reset, then a single byte in and out.
        add(0, 0, 8'h00, 0, 0, 0, 8'h00, 0);
        add(0, 0, 8'h00, 0, 0, 0, 8'h00, 0);
        add(1, 0, 8'h00, 0, 0, 0, 8'h00, 0);
        add(1, 1, 8'hA5, 0, 0, 1, 8'hA5, 0);
        add(1, 0, 8'h00, 0, 0, 1, 8'hA5, 0);
        add(1, 0, 8'h00, 1, 0, 0, 8'h00, 0);
        // Fill to full, then one dropped write.
        for (int k = 1; k <= 8; k++) add(1, 1, 8'(k), 0, 0, k, 8'h01, 0);
        add(1, 1, 8'h09, 0, 0, 8, 8'h01, 1);
        for (int k = 1; k <= 8; k++) add(1, 0, 8'h00, 1, 0, 8 - k, 8'(8'h01 + k), 1);
        add(1, 0, 8'h00, 0, 1, 0, 8'h00, 0);
        // Full bypass, drop racing a clear, then drain ending in the bypassed byte.
        for (int k = 0; k < 8; k++) add(1, 1, 8'(8'h10 + k), 0, 0, k + 1, 8'h10, 0);
        add(1, 1, 8'h20, 1, 0, 8, 8'h11, 0);
        add(1, 1, 8'h21, 0, 1, 8, 8'h11, 1);
        add(1, 0, 8'h00, 0, 1, 8, 8'h11, 0);
        add(1, 0, 8'h00, 1, 0, 7, 8'h12, 0);
        add(1, 0, 8'h00, 1, 0, 6, 8'h13, 0);
        add(1, 0, 8'h00, 1, 0, 5, 8'h14, 0);
        add(1, 0, 8'h00, 1, 0, 4, 8'h15, 0);
        add(1, 0, 8'h00, 1, 0, 3, 8'h16, 0);
        add(1, 0, 8'h00, 1, 0, 2, 8'h17, 0);
        add(1, 0, 8'h00, 1, 0, 1, 8'h20, 0);
        add(1, 0, 8'h00, 1, 0, 0, 8'h00, 0);
        // Push and pop together while empty: only the push happens.
        add(1, 1, 8'h66, 1, 0, 1, 8'h66, 0);
        add(1, 0, 8'h00, 1, 0, 0, 8'h00, 0);

        @(posedge clk);
        #1;
        foreach (tbl[n]) begin
            drive(tbl[n].rst_n, tbl[n].wr_en, tbl[n].wr_data, tbl[n].tx_ready, tbl[n].clr_ovf);
            step();
            chk_state(n, tbl[n].exp_cnt, tbl[n].exp_data, tbl[n].exp_ovf);
        end

        // Streaming across pointer wraps with the consumer ready every other cycle.
        mc = 0;
        for (int k = 0; k < 20; k++) begin
            b   = 8'(8'h30 + k);
            rdy = k[0];
            drive(1'b1, 1'b1, b, rdy, 1'b0);
            mpop  = (mc > 0) && rdy;
            mpush = (mc < DEPTH) || mpop;
            if (mpop) begin
                chk("stream_data", k, int'(bus.tx_data), int'(sb[0]));
                void'(sb.pop_front());
                mc--;
            end
            if (mpush) begin
                sb.push_back(b);
                mc++;
            end
            step();
            chk("stream_count", k, int'(bus.count), mc);
            chk("stream_bound", k, int'(bus.count <= 4'(DEPTH)), 1);
        end
        i = 0;
        while (sb.size() > 0 && i < 2 * DEPTH) begin
            drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
            chk("drain_valid", i, int'(bus.tx_valid), 1);
            chk("drain_data", i, int'(bus.tx_data), int'(sb[0]));
            void'(sb.pop_front());
            step();
            i++;
        end
        chk("drain_done", i, sb.size(), 0);
        chk_state(100, 0, 8'h00, 0);

        // Reset in the middle of a burst discards the queue and the coincident write.
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, 8'(8'hB0 + k), 1'b0, 1'b0);
            step();
        end
        chk_state(200, 5, 8'hB0, 0);
        drive(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0);
        step();
        chk_state(201, 0, 8'h00, 0);
        drive(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        step();
        chk_state(202, 1, 8'h55, 0);
        drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        step();
        chk_state(203, 0, 8'h00, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nic_tx_fifo.md
Name: nic_tx_fifo

Overview:
Byte FIFO between the OS simulator's send path and the UART controller's transmit input. It decouples bursty OS writes from the slower serial link. It absorbs up to DEPTH bytes and presents them first-word-fall-through to the controller with a valid/ready handshake. It reports fill level, almost-full and a sticky overflow flag back to the OS side.

Parameters:
DEPTH, 8, number of byte entries; power of two, minimum 2
ADDR_W, 3, log2(DEPTH); pointer width
AF_THRESH, 6, count at or above which almost_full asserts; range 1..DEPTH

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
wr_en  input  1  OS write strobe, one byte per cycle while high
wr_data  input  8  byte to enqueue, sampled when wr_en high
tx_data  output  8  head-of-queue byte, valid when tx_valid high
tx_valid  output  1  queue non-empty
tx_ready  input  1  controller can accept a byte this cycle
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
count  output  ADDR_W+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a write was dropped
clr_ovf  input  1  clears overflow

Behaviour:
- Reset (rst_n low at a clk edge): wr_ptr=0, rd_ptr=0, count=0, overflow=0. After reset: empty=1, full=0, almost_full=0, tx_valid=0. Storage array is not reset. tx_data is don't-care while tx_valid=0.
- Reset has priority over every other input in the same cycle. A reset mid-burst discards all queued bytes. tx_valid is 0 on the cycle after the reset edge.
- Push: accepted when wr_en=1 and (full=0 or pop occurs this cycle). The accepted byte is written at mem[wr_ptr], and wr_ptr increments modulo DEPTH.
- Pop: occurs when tx_valid=1 and tx_ready=1. rd_ptr increments modulo DEPTH. tx_ready while empty has no effect.
- FWFT: tx_data = mem[rd_ptr], combinational from registered storage. A byte written into an empty FIFO appears on tx_data with tx_valid=1 on the next cycle; write-to-valid latency is 1 cycle. No read latency after a pop: the next byte is presented on the following cycle.
- Count update per cycle: +1 on push only, -1 on pop only, unchanged on push and pop together or on neither.
- Simultaneous push and pop when full: both occur and count stays DEPTH.
- Simultaneous push and pop when empty: no pop happens (tx_valid=0), the push is accepted, and count becomes 1.
- full, empty and almost_full are derived from the registered count, so they are valid the cycle after the count change.
- Overflow: wr_en=1, full=1 and no pop sets overflow=1 on the next edge. The byte is dropped and the queue is unmodified.
- Clearing overflow: clr_ovf=1 clears it on the next edge. If a dropping write and clr_ovf occur in the same cycle, set wins (overflow=1).
- Pointer wrap: after DEPTH pushes, wr_ptr returns to 0. Ordering across the wrap is strictly FIFO.
- tx_data must hold stable while tx_valid=1 and tx_ready=0; the head never changes without a pop.
- No combinational path from tx_ready to wr_en acceptance other than the full-and-pop bypass.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, release -> empty=1, count=0, tx_valid=0, overflow=0, full=0.
- Single byte: wr_en pulse with 0xA5 while tx_ready=0 -> next cycle tx_valid=1, tx_data=0xA5, count=1. Assert tx_ready one cycle -> following cycle empty=1, count=0.
- Fill and overflow (DEPTH=8): push 0x01..0x08 with tx_ready=0 -> almost_full=1 after the 6th push, full=1 with count=8. Push 0x09 -> overflow=1, count stays 8. Drain -> outputs 0x01..0x08 in order with 0x09 absent. clr_ovf -> overflow=0.
- Full bypass: with FIFO full holding 0x10..0x17, assert wr_en=1 (0x20) and tx_ready=1 in the same cycle -> 0x10 popped, 0x20 accepted, count=8, overflow stays 0. Final drain ends with 0x20.
- Wrap and streaming: run 20 bytes 0x30..0x43 with continuous wr_en and tx_ready toggling every other cycle -> output order matches input exactly across pointer wraps, and count never exceeds 8.
- Reset mid-operation: with 5 bytes queued, pulse rst_n=0 for one cycle while wr_en=1 -> that write is ignored, count=0, tx_valid=0 next cycle. A subsequent push of 0x55 appears as the first output.
